// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, press/release pulses and press counter.
// Define BTN_LONG_PRESS_EN to build the hold timer and long_press output; otherwise long_press is tied low.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nbtn,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [3:0] press_count
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

  // The sample taken in IDLE/PRESSED that starts a debounce window counts as the
  // first stable sample, so the debounce states only need DEBOUNCE_CYCLES-1 more.
  localparam bit         SINGLE  = (DEBOUNCE_CYCLES <= 1);
  localparam logic [7:0] DB_LAST = 8'(SINGLE ? 0 : DEBOUNCE_CYCLES - 2);

  state_t     state, state_nxt;
  logic       meta_btn, sync_btn;
  logic [7:0] db_cnt, db_cnt_nxt;
  logic       level_nxt, press_nxt, release_nxt;
  logic [3:0] count_nxt;

  // Synchronizer: invert so that 1 means pressed from here on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_btn <= 1'b0;
      sync_btn <= 1'b0;
    end else begin
      meta_btn <= ~nbtn;
      sync_btn <= meta_btn;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      db_cnt        <= 8'd0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 4'd0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_cnt_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      press_count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    count_nxt   = press_count;
    case (state)
      IDLE: begin
        if (sync_btn) begin
          db_cnt_nxt = 8'd0;
          if (SINGLE) begin
            state_nxt = PRESSED;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
            count_nxt = press_count + 4'd1;
          end else begin
            state_nxt = PRESS_DB;
          end
        end
      end
      PRESS_DB: begin
        if (!sync_btn) begin
          state_nxt  = IDLE;
          db_cnt_nxt = 8'd0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = 8'd0;
          level_nxt  = 1'b1;
          press_nxt  = 1'b1;
          count_nxt  = press_count + 4'd1;
        end else begin
          db_cnt_nxt = db_cnt + 8'd1;
        end
      end
      PRESSED: begin
        if (!sync_btn) begin
          db_cnt_nxt = 8'd0;
          if (SINGLE) begin
            state_nxt   = IDLE;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
          end else begin
            state_nxt = RELEASE_DB;
          end
        end
      end
      RELEASE_DB: begin
        if (sync_btn) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = 8'd0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = IDLE;
          db_cnt_nxt  = 8'd0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = 8'd0;
      end
    endcase
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [15:0] HOLD_LAST = 16'(LONG_CYCLES - 1);

  logic [15:0] hold;

  // Hold timer runs only in PRESSED and is frozen across release bounces
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= 16'd0;
      long_press <= 1'b0;
    end else begin
      if (press_nxt)
        hold <= 16'd0;
      else if (state == PRESSED && hold != 16'hFFFF)
        hold <= hold + 16'd1;

      if (release_nxt)
        long_press <= 1'b0;
      else if (state == PRESSED && hold >= HOLD_LAST)
        long_press <= 1'b1;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable synchronized samples (legal range 1..255) that qualify a press or release.
REQ-002 The module SHALL have parameter LONG_CYCLES, default 16, giving the number of clk cycles in PRESSED (legal range 1..65535) that qualify a long press.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, a reset that is asynchronous and active-high.
REQ-005 The module SHALL have port nbtn, input, 1 bit, the raw asynchronous push-button (0 = pressed).
REQ-006 The module SHALL have port btn_level, output, 1 bit, the debounced button state (1 = pressed).
REQ-007 The module SHALL have port press_pulse, output, 1 bit, high for one cycle per qualified press.
REQ-008 The module SHALL have port release_pulse, output, 1 bit, high for one cycle per qualified release.
REQ-009 The module SHALL have port long_press, output, 1 bit, high while a qualified long press is held.
REQ-010 The module SHALL have port press_count, output, 4 bits, the running count of qualified presses.

Function
REQ-011 nbtn SHALL be inverted and passed through a two-flop synchronizer; the second flop (sync_btn) SHALL be the only value the FSM reads.
REQ-012 The FSM SHALL have states IDLE, PRESS_DB, PRESSED, RELEASE_DB, with an 8-bit debounce counter and a 16-bit hold timer.
REQ-013 In IDLE, sync_btn=1 SHALL move the FSM to PRESS_DB with debounce counter cleared.
REQ-014 In PRESS_DB, sync_btn=0 SHALL return the FSM to IDLE, with no output change (glitch rejected).
REQ-015 In PRESS_DB, after DEBOUNCE_CYCLES consecutive samples with sync_btn=1, the FSM SHALL enter PRESSED, set btn_level=1, pulse press_pulse, increment press_count, and clear the hold timer, all on the same edge.
REQ-016 press_pulse SHALL rise on the DEBOUNCE_CYCLES+2 rising edge after the first edge that samples nbtn=0, provided nbtn is held stable.
REQ-017 In PRESSED, the hold timer SHALL increment each cycle and saturate at its maximum.
REQ-018 In PRESSED, sync_btn=0 SHALL move the FSM to RELEASE_DB with debounce counter cleared.
REQ-019 In RELEASE_DB, sync_btn=1 SHALL return the FSM to PRESSED without clearing the hold timer and without any pulse.
REQ-020 In RELEASE_DB, after DEBOUNCE_CYCLES consecutive samples with sync_btn=0, the FSM SHALL enter IDLE, set btn_level=0 and long_press=0, and pulse release_pulse.
REQ-021 press_count SHALL wrap from 15 to 0 with no flag.
REQ-022 press_pulse and release_pulse SHALL never be high in the same cycle, and each SHALL be exactly one cycle wide.
REQ-023 All outputs SHALL be registered, with no combinational path from nbtn.

Reset
REQ-024 While rst=1: state=IDLE, synchronizer flops=0, counters=0, btn_level=0, press_pulse=0, release_pulse=0, long_press=0, press_count=0.
REQ-025 Reset asserted mid-press SHALL abort the press with no release_pulse.
REQ-026 After reset deasserts with the button still held, a new press SHALL be qualified per REQ-016.

Configuration
REQ-027 With macro BTN_LONG_PRESS_EN defined, long_press SHALL assert on the edge where the hold timer reaches LONG_CYCLES-1 in PRESSED, and SHALL stay high through RELEASE_DB bounces until REQ-020 clears it.
REQ-028 With BTN_LONG_PRESS_EN undefined, the hold timer SHALL be absent, long_press SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-029 Clean press: nbtn 1->0 held 20 cycles -> one press_pulse at edge 6, btn_level=1, press_count=1.
REQ-030 Glitch: nbtn low 3 cycles then high -> no pulses, btn_level stays 0, press_count stays 0.
REQ-031 Release bounce: while pressed, nbtn high 2 cycles then low, then high 10 cycles -> exactly one release_pulse, issued after the final 4 stable samples.
REQ-032 Long press (macro defined): hold 30 cycles -> long_press rises 16 cycles after press_pulse and clears with release_pulse; macro undefined -> long_press=0 throughout.
REQ-033 Wrap and reset: 17 clean presses -> press_count=1; rst pulse mid-press -> all outputs 0 and no release_pulse.
